instr_fetch_queue: RTL and testbench

Instruction fetch front end for the 19-bit/12-bit-PC single-cycle core. It sits directly upstream of the datapath's instruction register input. It fetches instructions from a wait-state instruction memory over a req/ack handshake and buffers them, tagged with their PC, in a small FIFO. It presents them to the datapath over a valid/ready handshake. On a taken branch or jump (`redirect`) it flushes all buffered and in-flight fetches and restarts at the new PC.

---
 rtl/instr_fetch_queue_if.sv | 27 ++
 rtl/instr_fetch_queue.sv | 131 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory req/ack side, datapath valid/ready side, redirect.
// master = fetch queue, slave = memory/datapath environment.
interface instr_fetch_queue_if;
    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 19;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               inst_valid;
    logic [INSTR_W-1:0] inst_out;
    logic [PC_W-1:0]    inst_pc;
    logic               inst_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_data, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_data, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetches over req/ack into a PC-tagged FIFO, presents over
// valid/ready, and flushes all buffered and in-flight fetches on redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 19;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t             state;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    stale_addr;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_next;
    logic               has_space;
    logic [PC_W-1:0]    pc_inc;

    // Head presentation and the push/pop/space decisions for this cycle.
    always_comb begin
        bus.inst_valid = (count != '0) & ~bus.redirect;
        bus.inst_out   = mem[rd_ptr].instr;
        bus.inst_pc    = mem[rd_ptr].pc;
        pop            = bus.inst_valid & bus.inst_ready;
        push           = (state == REQ) & bus.imem_ack & ~bus.redirect;
        count_next     = count + CNT_W'(push) - CNT_W'(pop);
        has_space      = count_next < CNT_W'(DEPTH);
        pc_inc         = fetch_pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            stale_addr    <= RESET_PC;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.redirect) begin
            // Flush wins over any same-cycle push or pop; a live handshake is finished in DISCARD.
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= bus.redirect_pc;
            case (state)
                REQ: begin
                    if (bus.imem_ack) begin
                        state        <= IDLE;
                        bus.imem_req <= 1'b0;
                    end else begin
                        state      <= DISCARD;
                        stale_addr <= bus.imem_addr;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state        <= IDLE;
                        bus.imem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;

            case (state)
                IDLE: begin
                    if (has_space) begin
                        state         <= REQ;
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        fetch_pc <= pc_inc;
                        if (has_space) begin
                            bus.imem_addr <= pc_inc;
                        end else begin
                            state        <= IDLE;
                            bus.imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    // FIFO was flushed on entry, so the restart request always has room.
                    if (bus.imem_ack) begin
                        state         <= REQ;
                        bus.imem_addr <= fetch_pc;
                    end else begin
                        bus.imem_addr <= stale_addr;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed phases push expected {pc,instr} entries,
// an independent monitor pops and compares on every inst_valid & inst_ready handshake.
module tb_instr_fetch_queue;
    logic clk;
    logic rst;
    int   npass;
    int   ntotal;
    int   mem_wait;
    int   wcnt;
    int   ack_total;
    logic [30:0] exp_q[$];

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(12'h010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait-state memory returning data = address, ack after mem_wait cycles of request.
    assign bus.imem_ack  = bus.imem_req && (wcnt >= mem_wait);
    assign bus.imem_data = {7'h0, bus.imem_addr};

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
        else                               wcnt <= wcnt + 1;
    end

    always @(negedge clk) begin
        if (bus.imem_req && bus.imem_ack) ack_total <= ack_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [11:0] pc);
        exp_q.push_back({pc, 7'h0, pc});
    endtask

    // Monitor: every handshake must match the front of the expected queue.
    always @(negedge clk) begin
        logic [30:0] e;
        if (rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop_pc", 32'(bus.inst_pc), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc",  32'(bus.inst_pc),  32'(e[30:19]));
                check("pop_out", 32'(bus.inst_out), 32'(e[18:0]));
            end
        end
    end

    task automatic redirect_to(input logic [11:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        @(posedge clk); #1;
        bus.redirect    = 1'b0;
    endtask

    // Hold ready high for exactly n handshakes, then drop it right after the last pop edge.
    task automatic consume(input int n, input int budget, output int span);
        int got;
        int first;
        int cyc;
        got = 0; first = -1; cyc = 0; span = 0;
        bus.inst_ready = 1'b1;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.inst_valid && bus.inst_ready) begin
                got++;
                if (first < 0) first = cyc;
                span = cyc - first;
            end
        end
        check("consume_count", 32'(got), 32'(n));
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
    endtask

    task automatic find_req(input logic [11:0] addr, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == addr && wcnt == 0) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        int base;
        npass = 0; ntotal = 0; mem_wait = 0; wcnt = 0; ack_total = 0;
        rst = 1'b0;
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 12'h000;

        // Reset state and first request timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(bus.imem_req),   32'd0);
        check("rst_addr",  32'(bus.imem_addr),  32'h010);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_out",   32'(bus.inst_out),   32'd0);
        check("rst_pc",    32'(bus.inst_pc),    32'd0);
        for (int i = 0; i < 16; i++) push_exp(12'(12'h010 + i));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("req_cycle1", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("req_cycle2",  32'(bus.imem_req),  32'd1);
        check("req_addr010", 32'(bus.imem_addr), 32'h010);
        consume(16, 100, span);
        check("throughput_span", 32'(span), 32'd15);

        // Back-pressure: exactly DEPTH acks then the request drops; drain resumes cleanly.
        redirect_to(12'h040);
        base = ack_total;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("full_acks",  32'(ack_total - base), 32'd4);
        check("full_req",   32'(bus.imem_req),     32'd0);
        check("full_valid", 32'(bus.inst_valid),   32'd1);
        for (int i = 0; i < 16; i++) push_exp(12'(12'h040 + i));
        @(posedge clk); #1;
        consume(16, 100, span);

        // PC wrap at 12'hFFF.
        redirect_to(12'hFFE);
        push_exp(12'hFFE); push_exp(12'hFFF); push_exp(12'h000); push_exp(12'h001);
        consume(4, 100, span);

        // 3-wait memory, redirect during the wait: stale address held, its data dropped.
        mem_wait = 3;
        redirect_to(12'h100);
        find_req(12'h100, "stale_setup");
        @(posedge clk); #1;
        redirect_to(12'h200);
        @(negedge clk);
        check("stale_req",  32'(bus.imem_req),  32'd1);
        check("stale_addr", 32'(bus.imem_addr), 32'h100);
        check("stale_wait", 32'(bus.imem_ack),  32'd0);
        @(negedge clk);
        check("stale_ack_addr", 32'(bus.imem_addr), 32'h100);
        check("stale_ack",      32'(bus.imem_ack),  32'd1);
        push_exp(12'h200); push_exp(12'h201); push_exp(12'h202);
        consume(3, 200, span);

        // Redirect in the same cycle as an ack and a pending pop.
        mem_wait = 0;
        redirect_to(12'h300);
        push_exp(12'h300); push_exp(12'h301);
        for (int i = 0; i < 4; i++) push_exp(12'(12'h350 + i));
        begin
            int got;
            got = 0;
            bus.inst_ready = 1'b1;
            for (int i = 0; i < 50 && got < 2; i++) begin
                @(negedge clk);
                if (bus.inst_valid && bus.inst_ready) got++;
            end
            check("pre_redirect_pops", 32'(got), 32'd2);
        end
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 12'h350;
        @(negedge clk);
        check("redir_valid_masked", 32'(bus.inst_valid), 32'd0);
        check("redir_ack_same",     32'(bus.imem_ack),   32'd1);
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("redir_empty", 32'(bus.inst_valid), 32'd0);
        check("redir_idle",  32'(bus.imem_req),   32'd0);
        @(negedge clk);
        check("redir_req",  32'(bus.imem_req),  32'd1);
        check("redir_addr", 32'(bus.imem_addr), 32'h350);
        consume(4, 100, span);

        // Reset asserted while in DISCARD.
        mem_wait = 3;
        redirect_to(12'h400);
        find_req(12'h400, "discard_setup");
        @(posedge clk); #1;
        redirect_to(12'h500);
        rst = 1'b0;
        @(negedge clk);
        check("pre_rst_discard", 32'(bus.imem_addr), 32'h400);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_wait = 0;
        push_exp(12'h010); push_exp(12'h011);
        @(negedge clk);
        check("midrst_req",   32'(bus.imem_req),   32'd0);
        check("midrst_valid", 32'(bus.inst_valid), 32'd0);
        check("midrst_pc",    32'(bus.inst_pc),    32'd0);
        @(negedge clk);
        check("restart_req",  32'(bus.imem_req),  32'd1);
        check("restart_addr", 32'(bus.imem_addr), 32'h010);
        @(posedge clk); #1;
        consume(2, 100, span);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
